// File: rtl/tx_port_gate_arbiter.sv
// tx_port_gate_arbiter: shares one TX engine among C_NUM_CHNL gate FIFOs.
// Whole framed transactions are granted round-robin and re-tagged per word.
// Ports:
//   CLK, RST_N      clock, async active-low reset
//   GATE_RD_DATA    per-gate FWFT word, MSB is the ctrl flag
//   GATE_RD_EMPTY   per-gate empty; word valid while low
//   GATE_RD_EN      per-gate pop (one-hot or zero)
//   OUT_DATA/KIND/CHNL/VALID, OUT_READY   registered valid/ready output
//   OUT_ERR         one-cycle framing error pulse (word dropped)
//   BUSY            a transaction is currently granted
module tx_port_gate_arbiter #(
    parameter int  C_NUM_CHNL   = 4,
    parameter int  C_DATA_WIDTH = 32,
    localparam int C_CHNL_W     = (C_NUM_CHNL > 1) ? $clog2(C_NUM_CHNL) : 1
) (
    input  logic                                   CLK,
    input  logic                                   RST_N,
    input  logic [C_NUM_CHNL*(C_DATA_WIDTH+1)-1:0] GATE_RD_DATA,
    input  logic [C_NUM_CHNL-1:0]                  GATE_RD_EMPTY,
    output logic [C_NUM_CHNL-1:0]                  GATE_RD_EN,
    output logic [C_DATA_WIDTH-1:0]                OUT_DATA,
    output logic [1:0]                             OUT_KIND,
    output logic [C_CHNL_W-1:0]                    OUT_CHNL,
    output logic                                   OUT_VALID,
    input  logic                                   OUT_READY,
    output logic                                   OUT_ERR,
    output logic                                   BUSY
);

    typedef enum logic {S_IDLE, S_XFER} state_e;
    typedef enum logic [1:0] {P_LEN, P_OFF, P_BODY, P_END2} phase_e;

    localparam logic [1:0] K_DATA = 2'd0;
    localparam logic [1:0] K_LEN  = 2'd1;
    localparam logic [1:0] K_OFF  = 2'd2;
    localparam logic [1:0] K_END  = 2'd3;

    state_e                  state_q, state_d;
    phase_e                  phase_q, phase_d;
    logic [C_CHNL_W-1:0]     grant_q, grant_d;
    logic [C_CHNL_W-1:0]     last_q, last_d;
    logic [31:0]             count_q, count_d;
    logic                    out_valid_q, out_valid_d;
    logic [C_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]              out_kind_q, out_kind_d;
    logic [C_CHNL_W-1:0]     out_chnl_q, out_chnl_d;
    logic                    out_err_q, out_err_d;

    logic [C_DATA_WIDTH:0]   gate_word [C_NUM_CHNL];
    logic [C_DATA_WIDTH:0]   rd_word;
    logic                    rd_ctrl;
    logic                    pop;

    logic                    rr_found;
    logic [C_CHNL_W-1:0]     rr_pick;
    logic [C_CHNL_W-1:0]     rr_sel;
    int                      rr_idx;

    logic                    emit;
    logic [1:0]              emit_kind;
    logic [C_DATA_WIDTH-1:0] emit_data;

    always_comb begin
        for (int g = 0; g < C_NUM_CHNL; g++) begin
            gate_word[g] = GATE_RD_DATA[g*(C_DATA_WIDTH+1) +: C_DATA_WIDTH+1];
        end
    end

    assign rd_word = gate_word[grant_q];
    assign rd_ctrl = rd_word[C_DATA_WIDTH];

    // Pop only when the output stage is free or being drained this cycle.
    assign pop = (state_q == S_XFER) && !GATE_RD_EMPTY[grant_q]
              && (!out_valid_q || OUT_READY);

    always_comb begin
        GATE_RD_EN = '0;
        if (pop) begin
            GATE_RD_EN[grant_q] = 1'b1;
        end
    end

    // Search upward from the gate after the last completed grant, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_q;
        rr_idx   = 0;
        rr_sel   = '0;
        for (int i = 1; i <= C_NUM_CHNL; i++) begin
            rr_idx = (int'(last_q) + i) % C_NUM_CHNL;
            rr_sel = rr_idx[C_CHNL_W-1:0];
            if (!rr_found && !GATE_RD_EMPTY[rr_sel]) begin
                rr_found = 1'b1;
                rr_pick  = rr_sel;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        grant_d     = grant_q;
        last_d      = last_q;
        count_d     = count_q;
        out_valid_d = out_valid_q && !OUT_READY;
        out_data_d  = out_data_q;
        out_kind_d  = out_kind_q;
        out_chnl_d  = out_chnl_q;
        out_err_d   = 1'b0;
        emit        = 1'b0;
        emit_kind   = K_DATA;
        emit_data   = rd_word[C_DATA_WIDTH-1:0];

        unique case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    phase_d = P_LEN;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (pop) begin
                    unique case (phase_q)
                        P_LEN: begin
                            if (rd_ctrl) begin
                                emit      = 1'b1;
                                emit_kind = K_LEN;
                                phase_d   = P_OFF;
                            end else begin
                                out_err_d = 1'b1;
                            end
                        end
                        P_OFF: begin
                            if (rd_ctrl) begin
                                emit      = 1'b1;
                                emit_kind = K_OFF;
                                count_d   = '0;
                                phase_d   = P_BODY;
                            end else begin
                                out_err_d = 1'b1;
                            end
                        end
                        P_BODY: begin
                            // First end marker is swallowed silently.
                            if (!rd_ctrl) begin
                                emit      = 1'b1;
                                emit_kind = K_DATA;
                                count_d   = count_q + 32'd1;
                            end else begin
                                phase_d = P_END2;
                            end
                        end
                        P_END2: begin
                            if (rd_ctrl) begin
                                emit      = 1'b1;
                                emit_kind = K_END;
                                emit_data = C_DATA_WIDTH'(count_q);
                                state_d   = S_IDLE;
                                last_d    = grant_q;
                                phase_d   = P_LEN;
                            end else begin
                                out_err_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
        endcase

        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = emit_data;
            out_kind_d  = emit_kind;
            out_chnl_d  = grant_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            phase_q     <= P_LEN;
            grant_q     <= '0;
            last_q      <= C_CHNL_W'(C_NUM_CHNL - 1);
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_kind_q  <= '0;
            out_chnl_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_kind_q  <= out_kind_d;
            out_chnl_q  <= out_chnl_d;
            out_err_q   <= out_err_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_KIND  = out_kind_q;
    assign OUT_CHNL  = out_chnl_q;
    assign OUT_ERR   = out_err_q;
    assign BUSY      = (state_q == S_XFER);

endmodule

// File: tb/tb_tx_port_gate_arbiter.sv
// tb_tx_port_gate_arbiter: directed and random frames through gate FIFO models,
// checked cycle by cycle against a transaction-level reference model.
module tb_tx_port_gate_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int CW = 2;

    typedef struct {
        logic [W:0]   raw;
        int           tag;   // 0 emitted, 1 framing error, 2 silent, 3 END
        logic [1:0]   kind;
        logic [W-1:0] data;
        int           chnl;
    } ent_t;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic [N*(W+1)-1:0] GATE_RD_DATA;
    logic [N-1:0]     GATE_RD_EMPTY;
    logic [N-1:0]     GATE_RD_EN;
    logic [W-1:0]     OUT_DATA;
    logic [1:0]       OUT_KIND;
    logic [CW-1:0]    OUT_CHNL;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             OUT_ERR;
    logic             BUSY;

    tx_port_gate_arbiter #(
        .C_NUM_CHNL   (N),
        .C_DATA_WIDTH (W)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .GATE_RD_DATA  (GATE_RD_DATA),
        .GATE_RD_EMPTY (GATE_RD_EMPTY),
        .GATE_RD_EN    (GATE_RD_EN),
        .OUT_DATA      (OUT_DATA),
        .OUT_KIND      (OUT_KIND),
        .OUT_CHNL      (OUT_CHNL),
        .OUT_VALID     (OUT_VALID),
        .OUT_READY     (OUT_READY),
        .OUT_ERR       (OUT_ERR),
        .BUSY          (BUSY)
    );

    always #5 CLK = ~CLK;

    int   checks   = 0;
    int   failures = 0;

    ent_t gq [N][$];
    bit   stall [N];
    bit   ready_pat [$];
    bit   rand_ready;

    bit   m_busy;
    bit   m_valid;
    bit   m_err;
    int   m_grant;
    int   m_last;
    ent_t m_out;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < N; g++) begin
            gq[g].delete();
            stall[g] = 1'b0;
        end
        ready_pat.delete();
        m_busy  = 1'b0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_grant = 0;
        m_last  = N - 1;
    endtask

    task automatic push_frame(input int g, input int len, input int off,
                              input bit last, input int nd,
                              input logic [W-1:0] base, input bit garbage,
                              input logic [W-1:0] gval);
        ent_t e;
        e.chnl = g;
        if (garbage) begin
            e.raw  = {1'b0, gval};
            e.tag  = 1;
            e.kind = 2'd0;
            e.data = '0;
            gq[g].push_back(e);
        end
        e.raw  = {1'b1, W'(len)};
        e.tag  = 0;
        e.kind = 2'd1;
        e.data = W'(len);
        gq[g].push_back(e);
        e.data = (W'(off) << 1) | W'(last);
        e.raw  = {1'b1, e.data};
        e.kind = 2'd2;
        gq[g].push_back(e);
        for (int i = 0; i < nd; i++) begin
            e.data = base + W'(i);
            e.raw  = {1'b0, e.data};
            e.kind = 2'd0;
            gq[g].push_back(e);
        end
        e.raw  = {1'b1, {W{1'b0}}};
        e.tag  = 2;
        e.kind = 2'd0;
        e.data = '0;
        gq[g].push_back(e);
        e.tag  = 3;
        e.kind = 2'd3;
        e.data = W'(nd);
        gq[g].push_back(e);
    endtask

    // One clock: drive at negedge, check at +1, advance the model at posedge.
    task automatic cycle();
        bit           ne [N];
        bit           rdy;
        bit           found;
        logic [N-1:0] exp_en;
        ent_t         e;
        bit           n_busy, n_valid, n_err;
        int           n_grant, n_last, g;
        ent_t         n_out;

        for (int k = 0; k < N; k++) begin
            ne[k] = (gq[k].size() > 0) && !stall[k];
            GATE_RD_EMPTY[k] = !ne[k];
            GATE_RD_DATA[k*(W+1) +: (W+1)] = ne[k] ? gq[k][0].raw : '0;
        end
        if (ready_pat.size() > 0) rdy = ready_pat.pop_front();
        else if (rand_ready)      rdy = 1'($urandom_range(0, 1));
        else                      rdy = 1'b1;
        OUT_READY = rdy;
        #1;
        chk("busy", BUSY, m_busy);
        chk("out_valid", OUT_VALID, m_valid);
        chk("out_err", OUT_ERR, m_err);
        if (m_valid) begin
            chk("out_kind", OUT_KIND, m_out.kind);
            chk("out_data", OUT_DATA, m_out.data);
            chk("out_chnl", OUT_CHNL, m_out.chnl);
        end
        n_busy  = m_busy;
        n_valid = m_valid && !rdy;
        n_err   = 1'b0;
        n_grant = m_grant;
        n_last  = m_last;
        n_out   = m_out;
        exp_en  = '0;
        if (!m_busy) begin
            found = 1'b0;
            for (int i = 1; i <= N; i++) begin
                g = (m_last + i) % N;
                if (!found && ne[g]) begin
                    found   = 1'b1;
                    n_grant = g;
                    n_busy  = 1'b1;
                end
            end
        end else if (ne[m_grant] && (!m_valid || rdy)) begin
            exp_en[m_grant] = 1'b1;
            e = gq[m_grant].pop_front();
            case (e.tag)
                0: begin
                    n_valid = 1'b1;
                    n_out   = e;
                end
                1: n_err = 1'b1;
                3: begin
                    n_valid = 1'b1;
                    n_out   = e;
                    n_busy  = 1'b0;
                    n_last  = m_grant;
                end
                default: ;
            endcase
        end
        chk("gate_rd_en", GATE_RD_EN, exp_en);
        @(posedge CLK);
        m_busy  = n_busy;
        m_valid = n_valid;
        m_err   = n_err;
        m_grant = n_grant;
        m_last  = n_last;
        m_out   = n_out;
        @(negedge CLK);
    endtask

    function automatic bit all_idle();
        bit r = !m_busy && !m_valid;
        for (int g = 0; g < N; g++) begin
            if (gq[g].size() != 0) r = 1'b0;
        end
        return r;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (!all_idle() && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, all_idle(), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, OUT_VALID, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_rden"}, GATE_RD_EN, 0);
        chk({tag, "_err"}, OUT_ERR, 0);
    endtask

    initial begin
        int n;
        int g;
        RST_N         = 1'b1;
        OUT_READY     = 1'b0;
        GATE_RD_EMPTY = '1;
        GATE_RD_DATA  = '0;
        rand_ready    = 1'b0;
        model_reset();
        #1 RST_N = 1'b0;
        #1;
        chk_reset_outputs("reset");
        chk("reset_data", OUT_DATA, 0);
        chk("reset_kind", OUT_KIND, 0);
        chk("reset_chnl", OUT_CHNL, 0);

        // Gates 1 and 3 loaded at reset release: gate 1 wins first.
        push_frame(1, 2, 'h5, 1'b0, 2, 'h110, 1'b0, '0);
        push_frame(3, 2, 'h7, 1'b1, 2, 'h330, 1'b0, '0);
        @(negedge CLK);
        RST_N = 1'b1;
        drain("drain_g1_g3", 100);

        // After gate 3 the search wraps to 0 ahead of gate 2.
        push_frame(2, 1, 'h2, 1'b0, 1, 'h220, 1'b0, '0);
        push_frame(0, 4, 'h10, 1'b1, 4, 'hA0, 1'b0, '0);
        drain("drain_g0_g2", 100);

        // Back-pressure inside the body of a 5-word frame.
        push_frame(1, 5, 'h3, 1'b0, 5, 'h500, 1'b0, '0);
        ready_pat = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 1};
        drain("drain_ready", 100);

        // Empty-body transaction.
        push_frame(2, 8, 'h4, 1'b0, 0, '0, 1'b0, '0);
        drain("drain_nodata", 100);

        // Stray data word ahead of a frame.
        push_frame(0, 3, 'h6, 1'b1, 3, 'hC0, 1'b1, 32'hDEAD);
        drain("drain_garbage", 100);

        // Reset in the middle of the body with a word held.
        push_frame(1, 6, 'h3, 1'b0, 6, 'h100, 1'b0, '0);
        ready_pat = '{1, 1, 1, 1, 0, 0, 0, 0};
        n = 0;
        while (!(m_valid && m_out.kind == 2'd0) && n < 50) begin
            cycle();
            n++;
        end
        chk("reach_body", m_valid && (m_out.kind == 2'd0), 1);
        #2 RST_N = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        model_reset();
        push_frame(3, 1, 'h1, 1'b0, 1, 'h3300, 1'b0, '0);
        push_frame(2, 2, 'h2, 1'b1, 2, 'h2200, 1'b0, '0);
        @(negedge CLK);
        RST_N = 1'b1;
        drain("drain_after_reset", 100);

        // Random traffic with stalls and back-pressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 600; k++) begin
            for (int s = 0; s < N; s++) begin
                stall[s] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 4) == 0) begin
                g = $urandom_range(0, N - 1);
                if (gq[g].size() < 30) begin
                    push_frame(g, $urandom_range(0, 255),
                               $urandom_range(0, 1023),
                               1'($urandom_range(0, 1)),
                               $urandom_range(0, 6), $urandom,
                               ($urandom_range(0, 7) == 0), $urandom);
                end
            end
            cycle();
        end
        for (int s = 0; s < N; s++) stall[s] = 1'b0;
        drain("drain_random", 3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
